// File: rtl/seg7_scan_scheduler.sv
// Refresh scheduler for an 8-digit 7-segment Pmod behind two chained 74HC595s.
// Buffers eight segment patterns and serialises {digit select, segments} per digit forever.
module seg7_scan_scheduler #(
  parameter int unsigned CLK_DIV          = 6250,
  parameter bit          DIGIT_ACTIVE_LOW = 1'b1,
  parameter int unsigned CLR_TICKS        = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wr_valid_i,
  output logic       wr_ready_o,
  input  logic [2:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  input  logic       blank_i,
  output logic       ser_o,
  output logic       sclk_o,
  output logic       rclk_o,
  output logic       srclr_n_o,
  output logic       frame_done_o
);

  typedef enum logic [1:0] {CLEAR, LOAD, SHIFT, LATCH} state_e;

  localparam logic [15:0] TickLast = 16'(CLK_DIV - 1);
  localparam logic [15:0] ClrLast  = 16'(CLR_TICKS - 1);
  localparam logic [7:0]  DselOff  = DIGIT_ACTIVE_LOW ? 8'hFF : 8'h00;

  state_e      state_q, state_d;
  logic [15:0] tickCnt_q, tickCnt_d;
  logic [15:0] clrCnt_q, clrCnt_d;
  logic [3:0]  bitCnt_q, bitCnt_d;
  logic        phaseB_q, phaseB_d;
  logic [1:0]  latchCnt_q, latchCnt_d;
  logic [15:0] word_q, word_d;
  logic [2:0]  digitIdx_q, digitIdx_d;
  logic        ser_q, ser_d;
  logic        sclk_q, sclk_d;
  logic        rclk_q, rclk_d;
  logic        srclrN_q, srclrN_d;
  logic        frameDone_q, frameDone_d;
  logic [7:0]  segBuf_q [8];
  logic [7:0]  dsel;
  logic        tick;

  // The tick counter pauses in LOAD so a digit takes exactly 1 + 35*CLK_DIV clocks.
  assign tick = (tickCnt_q == TickLast) && (state_q != LOAD);

  assign wr_ready_o   = (state_q != CLEAR) && (state_q != LOAD);
  assign ser_o        = ser_q;
  assign sclk_o       = sclk_q;
  assign rclk_o       = rclk_q;
  assign srclr_n_o    = srclrN_q;
  assign frame_done_o = frameDone_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 8; i++) segBuf_q[i] <= 8'h00;
    end else if (wr_valid_i && wr_ready_o) begin
      segBuf_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= CLEAR;
      tickCnt_q   <= '0;
      clrCnt_q    <= '0;
      bitCnt_q    <= '0;
      phaseB_q    <= 1'b0;
      latchCnt_q  <= '0;
      word_q      <= '0;
      digitIdx_q  <= '0;
      ser_q       <= 1'b0;
      sclk_q      <= 1'b0;
      rclk_q      <= 1'b0;
      srclrN_q    <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tickCnt_q   <= tickCnt_d;
      clrCnt_q    <= clrCnt_d;
      bitCnt_q    <= bitCnt_d;
      phaseB_q    <= phaseB_d;
      latchCnt_q  <= latchCnt_d;
      word_q      <= word_d;
      digitIdx_q  <= digitIdx_d;
      ser_q       <= ser_d;
      sclk_q      <= sclk_d;
      rclk_q      <= rclk_d;
      srclrN_q    <= srclrN_d;
      frameDone_q <= frameDone_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clrCnt_d    = clrCnt_q;
    bitCnt_d    = bitCnt_q;
    phaseB_d    = phaseB_q;
    latchCnt_d  = latchCnt_q;
    word_d      = word_q;
    digitIdx_d  = digitIdx_q;
    ser_d       = ser_q;
    sclk_d      = sclk_q;
    rclk_d      = rclk_q;
    srclrN_d    = srclrN_q;
    frameDone_d = 1'b0;
    dsel        = 8'h00;

    if (state_q == LOAD)        tickCnt_d = tickCnt_q;
    else if (tickCnt_q == TickLast) tickCnt_d = '0;
    else                        tickCnt_d = tickCnt_q + 16'd1;

    unique case (state_q)
      CLEAR: begin
        if (tick) begin
          if (clrCnt_q == ClrLast) begin
            srclrN_d = 1'b1;
            state_d  = LOAD;
          end else begin
            clrCnt_d = clrCnt_q + 16'd1;
          end
        end
      end
      LOAD: begin
        dsel = 8'h01 << digitIdx_q;
        if (DIGIT_ACTIVE_LOW) dsel = ~dsel;
        if (blank_i) word_d = {DselOff, 8'h00};
        else         word_d = {dsel, segBuf_q[digitIdx_q]};
        bitCnt_d = '0;
        phaseB_d = 1'b0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        if (tick) begin
          if (!phaseB_q) begin
            sclk_d   = 1'b0;
            ser_d    = word_q[4'd15 - bitCnt_q];
            phaseB_d = 1'b1;
          end else begin
            sclk_d   = 1'b1;
            phaseB_d = 1'b0;
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == 4'd15) begin
              latchCnt_d = '0;
              state_d    = LATCH;
            end
          end
        end
      end
      LATCH: begin
        if (tick) begin
          unique case (latchCnt_q)
            2'd0: begin
              sclk_d     = 1'b0;
              latchCnt_d = 2'd1;
            end
            2'd1: begin
              rclk_d     = 1'b1;
              latchCnt_d = 2'd2;
            end
            default: begin
              rclk_d      = 1'b0;
              digitIdx_d  = digitIdx_q + 3'd1;
              frameDone_d = (digitIdx_q == 3'd7);
              state_d     = LOAD;
            end
          endcase
        end
      end
      default: state_d = CLEAR;
    endcase
  end

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Directed bench for seg7_scan_scheduler with CLK_DIV=2, CLR_TICKS=2, active-low digit select.
// Monitors decode the 595 serial stream; each test task checks its own scenario.
module tb_seg7_scan_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       blank = 1'b0;
  logic       ser, sclk, rclk, srclr_n, frame_done;

  int errors = 0;
  int checks = 0;
  int cycle = 0;

  logic [15:0] shiftReg = '0;
  int          sclkRises = 0;
  logic [15:0] latched[$];
  int          sclkAtLatch[$];
  int          fdTimes[$];
  int          fdSizes[$];
  int          fdRun = 0;
  int          fdMaxRun = 0;

  seg7_scan_scheduler #(
    .CLK_DIV(2),
    .DIGIT_ACTIVE_LOW(1'b1),
    .CLR_TICKS(2)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .wr_valid_i(wr_valid),
    .wr_ready_o(wr_ready),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .blank_i(blank),
    .ser_o(ser),
    .sclk_o(sclk),
    .rclk_o(rclk),
    .srclr_n_o(srclr_n),
    .frame_done_o(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Model of the 595 chain: shift on sclk rise, capture on rclk rise.
  always @(posedge sclk) begin
    shiftReg  <= {shiftReg[14:0], ser};
    sclkRises <= sclkRises + 1;
  end

  always @(posedge rclk) begin
    latched.push_back(shiftReg);
    sclkAtLatch.push_back(sclkRises);
  end

  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      if (fdRun == 0) begin
        fdTimes.push_back(cycle);
        fdSizes.push_back(latched.size());
      end
      fdRun <= fdRun + 1;
      if (fdRun + 1 > fdMaxRun) fdMaxRun <= fdRun + 1;
    end else begin
      fdRun <= 0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic waitLatched(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (latched.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic waitRclkFall(output bit ok);
    logic prev;
    prev = rclk;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && rclk === 1'b0) begin
        ok = 1'b1;
        break;
      end
      prev = rclk;
    end
  endtask

  task automatic driveWrite(input logic [2:0] addr, input logic [7:0] data, output bit ok);
    wr_valid = 1'b1;
    wr_addr  = addr;
    wr_data  = data;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wr_ready === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
  endtask

  task automatic countClearClks(output int lowClks);
    lowClks = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (srclr_n === 1'b1) begin
        lowClks = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    int lowClks;
    logic [5:0] outs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    outs = {ser, sclk, rclk, srclr_n, frame_done, wr_ready};
    checks++;
    if (outs !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", outs, 6'b0);
    end
    rst_n = 1'b1;
    countClearClks(lowClks);
    checks++;
    if (lowClks !== 4) begin
      errors++;
      $display("[TB] FAIL clear_length: got %0d clks expected %0d", lowClks, 4);
    end
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_first_load: got %b expected 0", wr_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_first_shift: got %b expected 1", wr_ready);
    end
    waitLatched(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL word0_timeout: got %0d words expected 1", latched.size());
    end else begin
      checks++;
      if (latched[0] !== 16'hFE00) begin
        errors++;
        $display("[TB] FAIL word0: got %h expected %h", latched[0], 16'hFE00);
      end
      checks++;
      if (sclkAtLatch[0] !== 16) begin
        errors++;
        $display("[TB] FAIL word0_bits: got %0d expected 16", sclkAtLatch[0]);
      end
    end
  endtask

  task automatic test_write_digit3();
    bit ok, okW;
    driveWrite(3'd3, 8'h4F, okW);
    checks++;
    if (!okW) begin
      errors++;
      $display("[TB] FAIL write3_handshake: got no transfer expected transfer");
    end
    waitLatched(4, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL word3_timeout: got %0d words expected 4", latched.size());
    end else begin
      checks++;
      if (latched[1] !== 16'hFD00) begin
        errors++;
        $display("[TB] FAIL word1: got %h expected %h", latched[1], 16'hFD00);
      end
      checks++;
      if (latched[3] !== 16'hF74F) begin
        errors++;
        $display("[TB] FAIL word3: got %h expected %h", latched[3], 16'hF74F);
      end
      checks++;
      if (sclkAtLatch[3] - sclkAtLatch[2] !== 16) begin
        errors++;
        $display("[TB] FAIL word3_bits: got %0d expected 16", sclkAtLatch[3] - sclkAtLatch[2]);
      end
    end
  endtask

  task automatic test_write_across_load();
    bit ok;
    waitRclkFall(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL load4_timeout: got no rclk fall expected one");
    end
    wr_valid = 1'b1;
    wr_addr  = 3'd5;
    wr_data  = 8'h6D;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_in_load: got %b expected 0", wr_ready);
    end
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_load: got %b expected 1", wr_ready);
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    waitLatched(6, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL word5_timeout: got %0d words expected 6", latched.size());
    end else begin
      checks++;
      if (latched[4] !== 16'hEF00) begin
        errors++;
        $display("[TB] FAIL word4: got %h expected %h", latched[4], 16'hEF00);
      end
      checks++;
      if (latched[5] !== 16'hDF6D) begin
        errors++;
        $display("[TB] FAIL word5: got %h expected %h", latched[5], 16'hDF6D);
      end
    end
  endtask

  task automatic test_blank_and_inflight();
    bit ok, okW;
    waitLatched(10, ok);
    blank = 1'b1;
    repeat (12) @(negedge clk);
    blank = 1'b0;
    waitLatched(11, ok);
    waitRclkFall(ok);
    @(negedge clk);
    driveWrite(3'd3, 8'h06, okW);
    checks++;
    if (!okW) begin
      errors++;
      $display("[TB] FAIL write3b_handshake: got no transfer expected transfer");
    end
    waitLatched(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL frame2_timeout: got %0d words expected 20", latched.size());
    end else begin
      checks++;
      if (latched[8] !== 16'hFE00) begin
        errors++;
        $display("[TB] FAIL word8: got %h expected %h", latched[8], 16'hFE00);
      end
      checks++;
      if (latched[10] !== 16'hFF00) begin
        errors++;
        $display("[TB] FAIL blank_word: got %h expected %h", latched[10], 16'hFF00);
      end
      checks++;
      if (latched[11] !== 16'hF74F) begin
        errors++;
        $display("[TB] FAIL inflight_word: got %h expected %h", latched[11], 16'hF74F);
      end
      checks++;
      if (latched[19] !== 16'hF706) begin
        errors++;
        $display("[TB] FAIL next_scan_word: got %h expected %h", latched[19], 16'hF706);
      end
    end
  endtask

  task automatic test_frame_done();
    bit ok;
    waitLatched(24, ok);
    repeat (4) @(negedge clk);
    checks++;
    if (!ok || fdTimes.size() !== 3) begin
      errors++;
      $display("[TB] FAIL frame_count: got %0d pulses expected 3", fdTimes.size());
    end else begin
      checks++;
      if (fdSizes[0] !== 8 || fdSizes[1] !== 16) begin
        errors++;
        $display("[TB] FAIL frame_position: got %0d,%0d words expected 8,16", fdSizes[0], fdSizes[1]);
      end
      checks++;
      if (fdTimes[1] - fdTimes[0] !== 568) begin
        errors++;
        $display("[TB] FAIL frame_period1: got %0d expected 568", fdTimes[1] - fdTimes[0]);
      end
      checks++;
      if (fdTimes[2] - fdTimes[1] !== 568) begin
        errors++;
        $display("[TB] FAIL frame_period2: got %0d expected 568", fdTimes[2] - fdTimes[1]);
      end
      checks++;
      if (fdMaxRun !== 1) begin
        errors++;
        $display("[TB] FAIL frame_width: got %0d clks expected 1", fdMaxRun);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    bit ok, found;
    int base, lowClks;
    logic [5:0] outs;
    waitLatched(28, ok);
    waitRclkFall(ok);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sclk === 1'b1 && ser === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL digit4_shift: got no sclk high expected sclk high with ser 1");
    end
    rst_n = 1'b0;
    #1;
    outs = {ser, sclk, rclk, srclr_n, frame_done, wr_ready};
    checks++;
    if (outs !== 6'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: got %b expected %b", outs, 6'b0);
    end
    repeat (3) @(negedge clk);
    base = latched.size();
    rst_n = 1'b1;
    countClearClks(lowClks);
    checks++;
    if (lowClks !== 4) begin
      errors++;
      $display("[TB] FAIL clear_after_reset: got %0d clks expected 4", lowClks);
    end
    waitLatched(base + 6, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL restart_timeout: got %0d words expected %0d", latched.size(), base + 6);
    end else begin
      checks++;
      if (latched[base] !== 16'hFE00) begin
        errors++;
        $display("[TB] FAIL restart_word0: got %h expected %h", latched[base], 16'hFE00);
      end
      checks++;
      if (latched[base+3] !== 16'hF700) begin
        errors++;
        $display("[TB] FAIL cleared_word3: got %h expected %h", latched[base+3], 16'hF700);
      end
      checks++;
      if (latched[base+5] !== 16'hDF00) begin
        errors++;
        $display("[TB] FAIL cleared_word5: got %h expected %h", latched[base+5], 16'hDF00);
      end
    end
  endtask

  initial begin
    $display("[TB] seg7_scan_scheduler directed tests start");
    test_reset();
    test_write_digit3();
    test_write_across_load();
    test_blank_and_inflight();
    test_frame_done();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
